thumb_inst_align: RTL and testbench
===================================

# thumb_inst_align

Fetch-side aligner that sits directly upstream of the Thumb instruction pattern decoder. Accepts 32-bit aligned fetch words (two halfwords, little-endian order), buffers halfwords, and assembles complete 16-bit or 32-bit Thumb instructions. Presents them on a 32-bit `inst` bus in the decoder's format: 32-bit instructions as {hw1, hw2}; 16-bit instructions in `inst[31:16]` with `inst[15:0]` = 0. Handles branch flush, including odd-halfword targets.

## Interface
- `DEPTH_HW`, 4: halfword buffer depth; even, ≥4.
- `RESET_PC`, 32'h0000_0000: PC of the first instruction after reset; bit 0 must be 0.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `fetch_word` input 32: aligned fetch data; [15:0] lower-address halfword, [31:16] upper.
- `fetch_valid` input 1: `fetch_word` is valid.
- `fetch_ready` output 1: aligner accepts the word this cycle.
- `flush` input 1: discard all buffered state and restart at `flush_pc`.
- `flush_pc` input 32: restart address; bit 0 is ignored.
- `inst` output 32: assembled instruction in decoder format.
- `inst_is32` output 1: `inst` is a 32-bit encoding.
- `inst_pc` output 32: address of the first halfword of `inst`.
- `inst_valid` output 1: `inst`, `inst_is32` and `inst_pc` are valid.
- `inst_ready` input 1: decoder consumes the instruction.

## Operation
- **Buffer:** circular halfword FIFO, `DEPTH_HW` entries, with head/tail pointers and a count (0..`DEPTH_HW`).
- **Push:** a fetch transfer happens when `fetch_valid && fetch_ready`. It writes 2 halfwords, low half first.
  - Exception: if `drop_first` is set, it writes only `fetch_word[31:16]` and clears `drop_first`.
- **fetch_ready:**
  - 1 when `count ≤ DEPTH_HW-2` and `flush` = 0.
  - Purely combinational from registered count and `flush`.
- **32-bit detection:** head halfword bits [15:11] ∈ {11101, 11110, 11111} → 32-bit.
- **inst_valid:**
  - 16-bit head: valid when `count ≥ 1`.
  - 32-bit head: valid when `count ≥ 2`. With `count == 1` and a 32-bit head, `inst_valid` = 0 until the second halfword arrives.
- **Pop:** on `inst_valid && inst_ready`, remove 1 or 2 halfwords and advance `inst_pc` by 2 or 4.
- **Simultaneous push and pop:** both are legal in one cycle; count += pushed − popped.
- **flush:** highest priority.
  - Next edge: count = 0, pointers = 0, `inst_pc` = {`flush_pc[31:1]`, 0}, `drop_first` = `flush_pc[1]`.
  - Any fetch word or pop presented in the flush cycle is ignored; `fetch_ready` = 0 during `flush`.
  - Upstream is responsible for fetching from {`flush_pc[31:2]`, 00} after a flush.
- **Pointer wrap:** pointers wrap modulo `DEPTH_HW`. A 32-bit instruction may straddle the wrap point; hw2 is taken from (head+1) mod `DEPTH_HW`.
- **PC arithmetic:** 32-bit modulo; 32'hFFFF_FFFE + 2 wraps to 0.

## Timing
- **Reset values:** count = 0, `inst_pc` = `RESET_PC`, `drop_first` = `RESET_PC[1]`, `inst_valid` = 0, `inst` = 0, `inst_is32` = 0, `fetch_ready` = 1 (after reset deassertion).
- **Reset mid-operation:** asynchronously empties the buffer. No partial instruction survives.
- **Latency:** a word accepted at edge N is visible on `inst` / `inst_valid` after edge N (cycle N+1). There is no combinational path from `fetch_*` to `inst_*`.
- **Output derivation:** `inst`, `inst_is32` and `inst_valid` are combinational from buffer registers only (head entries and count).
- **Handshake rules:**
  - `inst` / `inst_pc` are stable while `inst_valid` is high and `inst_ready` is low.
  - The decoder may hold `inst_ready` high continuously.
- **Throughput:** sustained 1 instruction/cycle for 16-bit streams is limited by fetch at 2 hw/cycle. Full 32-bit streams sustain 1/cycle.
- **Flush-to-first-instruction:** 2 cycles minimum (flush edge, fetch edge).

## Structure
- **Package `thumb_pkg`:**
  - function `is_thumb32(hw[15:11])`
  - localparam `HW_W = 16`
  - `RESET_PC` default
- **Sub-module `thumb_hw_fifo`:** halfword circular buffer.
  - Push port: 1 or 2 halfwords.
  - Pop port: 1 or 2 halfwords.
  - Exposes head, head+1 and count.
  - Owns pointer wrap.
- **Top:** detection, `drop_first`, PC tracking, flush control.

## Test plan
- Reset, then push 32'hBF00_4408 → `inst` = 32'h4408_0000 (`is32` = 0, `pc` = 0), then `inst` = 32'hBF00_0000 (`pc` = 2).
- Push 32'hF000_F101, then 32'h4408_0001 → `inst` = 32'hF101_F000 (`is32` = 1, `pc` = 0); then 16-bit 32'h0001_0000, `pc` = 4.
- Push a word whose upper half is 16'hF100 (32-bit prefix), hold `fetch_valid` low → that instruction stays `inst_valid` = 0 until the next word supplies hw2, then the assembled instruction is presented, including across pointer wrap.
- `inst_ready` = 0 with `fetch_valid` = 1 constant → `fetch_ready` drops once count > `DEPTH_HW-2`; no halfword lost or duplicated.
- `flush` with `flush_pc` = 32'h0000_0102, next word 32'h4408_BF00 → only 32'h4408 taken; `inst` = 32'h4408_0000, `inst_pc` = 32'h102.
- Assert `rst_n` low while `count` = 3 and `inst_valid` = 1 → all outputs return to reset values immediately, asynchronously.

Source files
------------

// File: rtl/thumb_inst_align_pkg.sv
// Shared definitions for the Thumb fetch aligner.
// Halfword width, reset PC default and 32-bit prefix detection.
package thumb_pkg;

  localparam int HW_W = 16;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic is_thumb32(input logic [4:0] op);
    return (op == 5'b11101) || (op == 5'b11110) ||
           (op == 5'b11111);
  endfunction

endpackage

// File: rtl/thumb_inst_align_if.sv
// Fetch-side and decoder-side handshake bundle of the aligner.
// slave: aligner view; master: fetch unit plus decoder view.
interface thumb_inst_align_if;

  logic [31:0] fetch_word;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] inst;
  logic        inst_is32;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  modport slave (
    input  fetch_word, fetch_valid, flush, flush_pc,
    input  inst_ready,
    output fetch_ready, inst, inst_is32, inst_pc,
    output inst_valid
  );

  modport master (
    output fetch_word, fetch_valid, flush, flush_pc,
    output inst_ready,
    input  fetch_ready, inst, inst_is32, inst_pc,
    input  inst_valid
  );

endinterface

// File: rtl/thumb_inst_align_hw_fifo.sv
// Circular halfword buffer: push/pop 0..2 halfwords per cycle.
// Exposes the two oldest entries so a 32-bit op can straddle wrap.
module thumb_hw_fifo
  import thumb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic [1:0]      push_n,
  input  logic [HW_W-1:0] push_hw0,
  input  logic [HW_W-1:0] push_hw1,
  input  logic [1:0]      pop_n,
  output logic [HW_W-1:0] head_hw,
  output logic [HW_W-1:0] head1_hw,
  output logic [CW-1:0]   count
);

  localparam logic [PW:0] DEP = (PW + 1)'(DEPTH);

  logic [HW_W-1:0] mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   head1;
  logic [PW-1:0]   tail1;

  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input logic [1:0]    n
  );
    logic [PW:0] s;
    s = {1'b0, p} + (PW + 1)'(n);
    if (s >= DEP) s = s - DEP;
    return s[PW-1:0];
  endfunction

  assign head1    = wrap(head, 2'd1);
  assign tail1    = wrap(tail, 2'd1);
  assign head_hw  = mem[head];
  assign head1_hw = mem[head1];

  // Halfword storage, low half first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!clr) begin
      if (push_n != 2'd0) mem[tail] <= push_hw0;
      if (push_n == 2'd2) mem[tail1] <= push_hw1;
    end
  end

  // Pointers and occupancy; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= wrap(head, pop_n);
      tail  <= wrap(tail, push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

endmodule

// File: rtl/thumb_inst_align.sv
// Thumb fetch aligner: assembles 16/32-bit ops from fetch words.
// Tracks PC, odd-halfword flush targets and decoder handshake.
module thumb_inst_align
  import thumb_pkg::*;
#(
  parameter int          DEPTH_HW = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input logic               clk,
  input logic               rst_n,
  thumb_inst_align_if.slave bus
);

  localparam int CW = $clog2(DEPTH_HW + 1);

  logic [HW_W-1:0] head_hw;
  logic [HW_W-1:0] head1_hw;
  logic [CW-1:0]   count;
  logic [1:0]      push_n;
  logic [1:0]      pop_n;
  logic [HW_W-1:0] push_hw0;
  logic            is32;
  logic            valid;
  logic            push;
  logic            pop;
  logic            drop_first;
  logic [31:0]     pc_q;

  thumb_hw_fifo #(.DEPTH(DEPTH_HW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.flush),
    .push_n   (push_n),
    .push_hw0 (push_hw0),
    .push_hw1 (bus.fetch_word[31:16]),
    .pop_n    (pop_n),
    .head_hw  (head_hw),
    .head1_hw (head1_hw),
    .count    (count)
  );

  assign is32  = is_thumb32(head_hw[15:11]);
  assign valid = is32 ? (count >= CW'(2))
                      : (count >= CW'(1));

  assign bus.fetch_ready = (count <= CW'(DEPTH_HW - 2))
                         && !bus.flush;
  assign bus.inst_valid  = valid;
  assign bus.inst_is32   = valid && is32;
  assign bus.inst_pc     = pc_q;

  // Decoder format: 32-bit as {hw1, hw2}, 16-bit in the top half.
  always_comb begin
    bus.inst = '0;
    if (valid) begin
      bus.inst = is32 ? {head_hw, head1_hw}
                      : {head_hw, 16'h0000};
    end
  end

  // Transfer qualification; a flush cycle does nothing else.
  always_comb begin
    push     = bus.fetch_valid && bus.fetch_ready;
    pop      = valid && bus.inst_ready && !bus.flush;
    push_n   = 2'd0;
    pop_n    = 2'd0;
    push_hw0 = bus.fetch_word[15:0];
    if (push) begin
      push_n = drop_first ? 2'd1 : 2'd2;
      if (drop_first) push_hw0 = bus.fetch_word[31:16];
    end
    if (pop) pop_n = is32 ? 2'd2 : 2'd1;
  end

  // PC tracking and odd-target halfword drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      drop_first <= RESET_PC[1];
    end else if (bus.flush) begin
      pc_q       <= {bus.flush_pc[31:1], 1'b0};
      drop_first <= bus.flush_pc[1];
    end else begin
      if (pop) pc_q <= pc_q + (is32 ? 32'd4 : 32'd2);
      if (push) drop_first <= 1'b0;
    end
  end

endmodule

// File: tb/tb_thumb_inst_align.sv
// Directed vector bench for thumb_inst_align (DEPTH_HW = 4).
// Table of per-cycle stimulus/expectations plus async reset check.
module tb_thumb_inst_align;
  import thumb_pkg::*;

  typedef struct {
    logic        fv;
    logic [31:0] word;
    logic        rdy;
    logic        fl;
    logic [31:0] fpc;
    logic        ev;
    logic [31:0] einst;
    logic        e32;
    logic [31:0] epc;
    logic        efr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vq[$];

  thumb_inst_align_if bus();

  thumb_inst_align #(
    .DEPTH_HW (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic fv, input logic [31:0] word,
                     input logic rdy, input logic fl,
                     input logic [31:0] fpc, input logic ev,
                     input logic [31:0] einst, input logic e32,
                     input logic [31:0] epc, input logic efr);
    vec_t v;
    v.fv = fv; v.word = word; v.rdy = rdy; v.fl = fl;
    v.fpc = fpc; v.ev = ev; v.einst = einst; v.e32 = e32;
    v.epc = epc; v.efr = efr;
    vq.push_back(v);
  endtask

  task automatic drive(input logic fv, input logic [31:0] word,
                       input logic rdy);
    bus.fetch_valid = fv;
    bus.fetch_word  = word;
    bus.inst_ready  = rdy;
    bus.flush       = 1'b0;
    bus.flush_pc    = 32'h0;
  endtask

  task automatic chk_out(input string nm, input logic ev,
                         input logic [31:0] einst, input logic e32,
                         input logic [31:0] epc, input logic efr);
    chk({nm, " valid"}, {31'b0, bus.inst_valid}, {31'b0, ev});
    chk({nm, " inst"}, bus.inst, einst);
    chk({nm, " is32"}, {31'b0, bus.inst_is32}, {31'b0, e32});
    chk({nm, " pc"}, bus.inst_pc, epc);
    chk({nm, " fready"}, {31'b0, bus.fetch_ready}, {31'b0, efr});
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0);
    // fv word rdy fl fpc | valid inst is32 pc fready
    add(0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    add(1, 32'hBF00_4408, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    add(0, 32'h0, 1, 0, 0, 1, 32'h4408_0000, 0, 32'h0, 1);
    add(0, 32'h0, 1, 0, 0, 1, 32'hBF00_0000, 0, 32'h2, 1);
    add(1, 32'hDEAD_BEEF, 1, 1, 32'h0, 0, 32'h0, 0, 32'h4, 0);
    add(1, 32'hF000_F101, 1, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    add(1, 32'h4408_0001, 0, 0, 0, 1, 32'hF101_F000, 1, 32'h0, 1);
    add(1, 32'hCAFE_CAFE, 1, 0, 0, 1, 32'hF101_F000, 1, 32'h0, 0);
    add(0, 32'h0, 1, 0, 0, 1, 32'h0001_0000, 0, 32'h4, 1);
    add(0, 32'h0, 1, 0, 0, 1, 32'h4408_0000, 0, 32'h6, 1);
    add(1, 32'hBF00_4408, 1, 0, 0, 0, 32'h0, 0, 32'h8, 1);
    add(0, 32'h0, 1, 0, 0, 1, 32'h4408_0000, 0, 32'h8, 1);
    add(1, 32'hF100_4408, 1, 0, 0, 1, 32'hBF00_0000, 0, 32'hA, 1);
    add(0, 32'h0, 1, 0, 0, 1, 32'h4408_0000, 0, 32'hC, 1);
    add(0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 32'hE, 1);
    add(0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 32'hE, 1);
    add(1, 32'hBF00_F200, 1, 0, 0, 0, 32'h0, 0, 32'hE, 1);
    add(0, 32'h0, 1, 0, 0, 1, 32'hF100_F200, 1, 32'hE, 0);
    add(0, 32'h0, 1, 0, 0, 1, 32'hBF00_0000, 0, 32'h12, 1);
    add(1, 32'h2222_1111, 0, 0, 0, 0, 32'h0, 0, 32'h14, 1);
    add(1, 32'h4444_3333, 0, 0, 0, 1, 32'h1111_0000, 0, 32'h14, 1);
    add(1, 32'h6666_5555, 0, 0, 0, 1, 32'h1111_0000, 0, 32'h14, 0);
    add(1, 32'h6666_5555, 1, 0, 0, 1, 32'h1111_0000, 0, 32'h14, 0);
    add(1, 32'h6666_5555, 1, 0, 0, 1, 32'h2222_0000, 0, 32'h16, 0);
    add(1, 32'h6666_5555, 1, 0, 0, 1, 32'h3333_0000, 0, 32'h18, 1);
    add(0, 32'h0, 1, 0, 0, 1, 32'h4444_0000, 0, 32'h1A, 0);
    add(0, 32'h0, 1, 0, 0, 1, 32'h5555_0000, 0, 32'h1C, 1);
    add(0, 32'h0, 1, 0, 0, 1, 32'h6666_0000, 0, 32'h1E, 1);
    add(1, 32'h1234_5678, 1, 1, 32'h102, 0, 32'h0, 0, 32'h20, 0);
    add(1, 32'h4408_BF00, 1, 0, 0, 0, 32'h0, 0, 32'h102, 1);
    add(0, 32'h0, 1, 0, 0, 1, 32'h4408_0000, 0, 32'h102, 1);
    add(0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h104, 1);
    add(0, 32'h0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h104, 0);
    add(1, 32'h4444_3333, 1, 0, 0, 0, 32'h0, 0, 32'hFFFF_FFFC, 1);
    add(0, 32'h0, 1, 0, 0, 1, 32'h3333_0000, 0, 32'hFFFF_FFFC, 1);
    add(0, 32'h0, 1, 0, 0, 1, 32'h4444_0000, 0, 32'hFFFF_FFFE, 1);
    add(0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].fv, vq[i].word, vq[i].rdy);
      bus.flush    = vq[i].fl;
      bus.flush_pc = vq[i].fpc;
      #1;
      chk_out($sformatf("v%0d", i), vq[i].ev, vq[i].einst,
              vq[i].e32, vq[i].epc, vq[i].efr);
    end

    // Async reset with three halfwords buffered and an op pending.
    @(negedge clk);
    drive(1'b1, 32'h2222_1111, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h4444_3333, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0);
    #1;
    chk_out("pre_rst", 1'b1, 32'h2222_0000, 1'b0, 32'h2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst valid", {31'b0, bus.inst_valid}, 32'h0);
    chk("rst inst", bus.inst, 32'h0);
    chk("rst is32", {31'b0, bus.inst_is32}, 32'h0);
    chk("rst pc", bus.inst_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("post_rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
